// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave bridge FSM state type.
// Imported by the bridge top and its strobe generator.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe and size/alignment check for one AHB transfer.
// Ports: addr_lo/hsize in; strb (little-endian lanes), size_ok out.
module ahb_strb_gen
    import ahb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int LW         = $clog2(NB)
) (
    input  logic [LW-1:0] addr_lo,
    input  logic [2:0]    hsize,
    output logic [NB-1:0] strb,
    output logic          size_ok
);

    always_comb begin
        int nbytes;
        int lo;
        nbytes  = 1 << hsize;
        lo      = int'(addr_lo);
        size_ok = (int'(hsize) <= LW)
               && ((lo & (nbytes - 1)) == 0);
        strb    = '0;
        for (int i = 0; i < NB; i++) begin
            strb[i] = (i >= lo) && (i < lo + nbytes);
        end
    end

endmodule

// File: rtl/ahb_slave_bridge.sv
// AHB-Lite slave endpoint bridging to a req/ack back end.
// Ports: AHB slave side (h*), back-end side (be_*); all outputs registered
// except be_wdata, which forwards hwdata.
module ahb_slave_bridge
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    be_req,
    output logic                    be_we,
    output logic [ADDR_WIDTH-1:0]   be_addr,
    output logic [DATA_WIDTH/8-1:0] be_wstrb,
    output logic [DATA_WIDTH-1:0]   be_wdata,
    input  logic                    be_ack,
    input  logic [DATA_WIDTH-1:0]   be_rdata
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int LW = $clog2(NB);

    // MEM_BYTES is assumed to be a power of two.
    localparam logic [ADDR_WIDTH-1:0] LIMIT =
        ADDR_WIDTH'(MEM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK =
        ADDR_WIDTH'(MEM_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK =
        ADDR_WIDTH'(NB - 1);

    bridge_state_e state;

    logic [NB-1:0] strb;
    logic          size_ok;
    logic          active;
    logic          take;
    logic          legal;

    ahb_strb_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb (
        .addr_lo (haddr[LW-1:0]),
        .hsize   (hsize),
        .strb    (strb),
        .size_ok (size_ok)
    );

    assign active = (htrans == HTRANS_NONSEQ)
                 || (htrans == HTRANS_SEQ);
    assign take   = hsel && hready && active;
    assign legal  = size_ok && (haddr < LIMIT);

    assign be_wdata = hwdata;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            hrdata    <= '0;
            be_req    <= 1'b0;
            be_we     <= 1'b0;
            be_addr   <= '0;
            be_wstrb  <= '0;
        end else begin
            unique case (state)
                ST_ACCESS: begin
                    if (be_ack) begin
                        state     <= ST_IDLE;
                        be_req    <= 1'b0;
                        hreadyout <= 1'b1;
                        if (!be_we) begin
                            hrdata <= be_rdata;
                        end
                    end
                end
                ST_ERR1: begin
                    // Second ERROR cycle: hresp stays high,
                    // hreadyout rises to end the transfer.
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                end
                default: begin
                    // IDLE and ERR2 both accept a new address
                    // phase, so pipelined transfers lose no cycle.
                    hresp     <= HRESP_OKAY;
                    hreadyout <= 1'b1;
                    state     <= ST_IDLE;
                    if (take && legal) begin
                        state     <= ST_ACCESS;
                        hreadyout <= 1'b0;
                        be_req    <= 1'b1;
                        be_we     <= hwrite;
                        be_addr   <= haddr & OFS_MASK
                                   & ~LANE_MASK;
                        be_wstrb  <= hwrite ? strb : '1;
                    end else if (take) begin
                        state     <= ST_ERR1;
                        hreadyout <= 1'b0;
                        hresp     <= HRESP_ERROR;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_bridge.sv
// Self-checking bench for ahb_slave_bridge.
// Vector table plus burst, error-pipelining and reset sequences.
module tb_ahb_slave_bridge;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        be_req;
    logic        be_we;
    logic [31:0] be_addr;
    logic [3:0]  be_wstrb;
    logic [31:0] be_wdata;
    logic        be_ack;
    logic [31:0] be_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_hrdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } be_exp_t;

    be_exp_t sbq[$];

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] be_addr;
        logic [3:0]  strb;
    } vec_t;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
    } beat_t;

    vec_t  vt[10];
    beat_t bt[8];

    ahb_slave_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_BYTES  (4096)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .be_req    (be_req),
        .be_we     (be_we),
        .be_addr   (be_addr),
        .be_wstrb  (be_wstrb),
        .be_wdata  (be_wdata),
        .be_ack    (be_ack),
        .be_rdata  (be_rdata)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h",
                     nm, act, exp);
        end
    endtask

    task automatic sb_pop(input string nm);
        be_exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s_sb: got empty want entry", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_we"}, be_we, e.we);
            chk({nm, "_addr"}, be_addr, e.addr);
            chk({nm, "_strb"}, be_wstrb, e.strb);
            if (e.we) begin
                chk({nm, "_wdata"}, be_wdata, e.wdata);
            end
        end
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'b00;
        hready = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        hsel   = 1'b1;
        hready = 1'b1;
        htrans = 2'b10;
        haddr  = v.addr;
        hwrite = v.write;
        hsize  = v.size;
        if (!v.err) begin
            sbq.push_back('{v.write, v.be_addr,
                            v.strb, v.wdata});
        end
        tick();
        idle_bus();
        hwdata = v.wdata;
        #1;
        if (v.err) begin
            chk({v.name, "_e1_resp"}, hresp, 1);
            chk({v.name, "_e1_rdy"}, hreadyout, 0);
            chk({v.name, "_e1_req"}, be_req, 0);
            tick();
            chk({v.name, "_e2_resp"}, hresp, 1);
            chk({v.name, "_e2_rdy"}, hreadyout, 1);
            chk({v.name, "_e2_req"}, be_req, 0);
            tick();
            chk({v.name, "_e3_resp"}, hresp, 0);
            chk({v.name, "_e3_rdy"}, hreadyout, 1);
        end else begin
            for (int k = 1; k <= v.dly; k++) begin
                chk({v.name, "_req"}, be_req, 1);
                chk({v.name, "_wait"}, hreadyout, 0);
                chk({v.name, "_okay"}, hresp, 0);
                if (k == 1) begin
                    sb_pop(v.name);
                end
                if (k == v.dly) begin
                    be_ack   = 1'b1;
                    be_rdata = v.rdata;
                end
                tick();
                be_ack = 1'b0;
                #1;
            end
            if (!v.write) begin
                exp_hrdata = v.rdata;
            end
            chk({v.name, "_done_rdy"}, hreadyout, 1);
            chk({v.name, "_done_req"}, be_req, 0);
            chk({v.name, "_done_resp"}, hresp, 0);
            chk({v.name, "_hrdata"}, hrdata, exp_hrdata);
        end
    endtask

    initial begin
        int nreq;
        logic xf;
        logic [31:0] bd;

        vt[0] = '{"wr_w10", 1, 32'h10, 3'd2, 32'hA5A5_1234,
                  1, 32'h0, 0, 32'h10, 4'hF};
        vt[1] = '{"rd_w20", 0, 32'h20, 3'd2, 32'h0,
                  3, 32'hDEAD_BEEF, 0, 32'h20, 4'hF};
        vt[2] = '{"wr_h02", 1, 32'h2, 3'd1, 32'h1111_2222,
                  1, 32'h0, 0, 32'h0, 4'b1100};
        vt[3] = '{"wr_b07", 1, 32'h7, 3'd0, 32'h3300_0000,
                  2, 32'h0, 0, 32'h4, 4'b1000};
        vt[4] = '{"rd_b05", 0, 32'h5, 3'd0, 32'h0,
                  1, 32'h1234_5678, 0, 32'h4, 4'hF};
        vt[5] = '{"err_mis", 0, 32'h1, 3'd2, 32'h0,
                  1, 32'h0, 1, 32'h0, 4'h0};
        vt[6] = '{"err_rng", 1, 32'h1000, 3'd2, 32'h0,
                  1, 32'h0, 1, 32'h0, 4'h0};
        vt[7] = '{"err_siz", 0, 32'h8, 3'd3, 32'h0,
                  1, 32'h0, 1, 32'h0, 4'h0};
        vt[8] = '{"err_h03", 1, 32'h3, 3'd1, 32'h0,
                  1, 32'h0, 1, 32'h0, 4'h0};
        vt[9] = '{"wr_wffc", 1, 32'hFFC, 3'd2, 32'hCAFE_0FFC,
                  2, 32'h0, 0, 32'hFFC, 4'hF};

        bt[0] = '{1'b1, 2'b10, 32'h100};
        bt[1] = '{1'b1, 2'b11, 32'h104};
        bt[2] = '{1'b1, 2'b01, 32'h108};
        bt[3] = '{1'b1, 2'b11, 32'h108};
        bt[4] = '{1'b1, 2'b00, 32'h0};
        bt[5] = '{1'b0, 2'b10, 32'h200};
        bt[6] = '{1'b1, 2'b10, 32'h10C};
        bt[7] = '{1'b1, 2'b00, 32'h0};

        hreset   = 1'b1;
        hsel     = 1'b0;
        haddr    = '0;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hsize    = 3'd2;
        hwdata   = '0;
        hready   = 1'b1;
        be_ack   = 1'b0;
        be_rdata = '0;
        exp_hrdata = '0;
        tick();
        tick();
        hreset = 1'b0;
        chk("rst_rdy", hreadyout, 1);
        chk("rst_resp", hresp, 0);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_req", be_req, 0);
        chk("rst_we", be_we, 0);
        chk("rst_addr", be_addr, 0);
        chk("rst_strb", be_wstrb, 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i]);
        end

        // Illegal access, then legal NONSEQ issued in ERR2.
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = 32'h1;
        hwrite = 1'b0;
        hsize  = 3'd2;
        tick();
        idle_bus();
        chk("pipe_e1_resp", hresp, 1);
        chk("pipe_e1_rdy", hreadyout, 0);
        tick();
        chk("pipe_e2_resp", hresp, 1);
        chk("pipe_e2_rdy", hreadyout, 1);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = 32'h40;
        hwrite = 1'b0;
        sbq.push_back('{1'b0, 32'h40, 4'hF, 32'h0});
        tick();
        idle_bus();
        chk("pipe_req", be_req, 1);
        chk("pipe_resp", hresp, 0);
        chk("pipe_wait", hreadyout, 0);
        sb_pop("pipe");
        be_ack   = 1'b1;
        be_rdata = 32'h0BAD_F00D;
        tick();
        be_ack = 1'b0;
        exp_hrdata = 32'h0BAD_F00D;
        chk("pipe_rdy", hreadyout, 1);
        chk("pipe_hrdata", hrdata, exp_hrdata);

        // Burst with immediate acks and idle-type beats.
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst%0d_in_rdy", i),
                hreadyout, 1);
            hsel   = bt[i].sel;
            htrans = bt[i].trans;
            haddr  = bt[i].addr;
            hwrite = 1'b1;
            hsize  = 3'd2;
            hready = 1'b1;
            xf = bt[i].sel && bt[i].trans[1];
            bd = 32'hB000_0000 | bt[i].addr;
            if (xf) begin
                sbq.push_back('{1'b1, bt[i].addr, 4'hF, bd});
            end
            tick();
            idle_bus();
            if (xf) begin
                hwdata = bd;
                be_ack = 1'b1;
                #1;
                chk($sformatf("burst%0d_req", i), be_req, 1);
                chk($sformatf("burst%0d_wait", i),
                    hreadyout, 0);
                if (be_req) begin
                    nreq++;
                end
                sb_pop($sformatf("burst%0d", i));
                tick();
                be_ack = 1'b0;
            end else begin
                chk($sformatf("burst%0d_zw_rdy", i),
                    hreadyout, 1);
                chk($sformatf("burst%0d_zw_resp", i),
                    hresp, 0);
                chk($sformatf("burst%0d_zw_req", i),
                    be_req, 0);
            end
        end
        chk("burst_nreq", nreq, 4);
        chk("burst_sb_empty", sbq.size(), 0);

        // Reset in the second cycle of a pending read.
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = 32'h30;
        hwrite = 1'b0;
        hsize  = 3'd2;
        tick();
        idle_bus();
        chk("rr_req1", be_req, 1);
        tick();
        chk("rr_req2", be_req, 1);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        exp_hrdata = '0;
        chk("rr_req", be_req, 0);
        chk("rr_rdy", hreadyout, 1);
        chk("rr_resp", hresp, 0);
        chk("rr_hrdata", hrdata, exp_hrdata);
        chk("rr_strb", be_wstrb, 0);
        be_ack   = 1'b1;
        be_rdata = 32'h5555_5555;
        tick();
        be_ack = 1'b0;
        chk("late_hrdata", hrdata, exp_hrdata);
        chk("late_rdy", hreadyout, 1);
        chk("late_req", be_req, 0);

        run_vec(vt[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
